branch_target_predictor: RTL and testbench
==========================================

BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 The block SHALL use one clock and synchronous active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 Parameter: ENTRIES, default 32, number of BTB and pattern-table entries (power of two, index width IW = log2(ENTRIES)).
REQ-003 Parameter: HIST, default IW, global history register width (HIST <= IW).
REQ-004 current_pc  input  32  IF-stage PC being fetched.
REQ-005 predicted_pc  output  32  PC to fetch next cycle; this is the not-taken/predicted next PC consumed by the PC-select/flush logic.
REQ-006 predict_taken  output  1  1 when predicted_pc comes from the BTB.
REQ-007 update_valid  input  1  EX stage has a resolved control-flow instruction this cycle.
REQ-008 update_pc  input  32  PC of the resolved instruction.
REQ-009 update_target  input  32  resolved target address.
REQ-010 update_taken  input  1  resolved direction.
REQ-011 update_is_jump  input  1  instruction is JAL/JALR (unconditional).
REQ-012 update_is_branch  input  1  instruction is a conditional branch.

Function
REQ-013 Storage SHALL be: BTB of ENTRIES x {valid, is_jump, tag = pc[31:IW+2], target[31:0]}; pattern table (PHT) of ENTRIES 2-bit saturating counters; HIST-bit global history register (GHR).
REQ-014 BTB index SHALL be pc[IW+1:2]; PHT index SHALL be pc[IW+1:2] XOR zero-extended GHR.
REQ-015 Lookup SHALL be combinational from current_pc and current state: hit = valid AND tag match.
REQ-016 predict_taken SHALL be hit AND (is_jump OR PHT counter >= 2'b10).
REQ-017 predicted_pc SHALL be BTB target when predict_taken, else current_pc + 4 (32-bit wrap: 0xFFFFFFFC -> 0x00000000).
REQ-018 All updates SHALL occur on the rising clk edge only when update_valid = 1 and reset = 0.
REQ-019 If update_valid and neither update_is_branch nor update_is_jump, state SHALL be unchanged.
REQ-020 Jump update: BTB[idx(update_pc)] <= {1, 1, tag, update_target}; PHT and GHR unchanged.
REQ-021 Branch update, taken: BTB entry written {1, 0, tag, update_target}; PHT counter at idx(update_pc) XOR GHR incremented, saturating at 2'b11.
REQ-022 Branch update, not taken: BTB entry untouched; PHT counter decremented, saturating at 2'b00.
REQ-023 Branch update SHALL shift GHR left by one, inserting update_taken at bit 0, discarding the MSB; the PHT index for that update uses the pre-shift GHR.
REQ-024 If update_is_branch and update_is_jump are both 1, jump behaviour SHALL take precedence and the branch update SHALL be suppressed.
REQ-025 Same-cycle lookup and update to the same entry: lookup SHALL return pre-update contents; the new value is visible from the next cycle.
REQ-026 A BTB write to an index holding a different tag SHALL overwrite it (direct-mapped, no alias protection).
REQ-027 The block SHALL NOT stall or back-pressure; every update_valid pulse is consumed in its cycle.

Reset
REQ-028 On reset: all BTB valid bits 0, all PHT counters 2'b01 (weakly not taken), GHR all-zero.
REQ-029 During reset, predict_taken = 0 and predicted_pc = current_pc + 4.
REQ-030 Reset asserted mid-operation SHALL discard all learned state within one edge, and an update_valid in that cycle SHALL be ignored.

Verification
REQ-031 After reset, current_pc = 0x100 -> predicted_pc = 0x104, predict_taken = 0.
REQ-032 Jump update pc = 0x200, target = 0x800, then current_pc = 0x200 -> predicted_pc = 0x800, predict_taken = 1; current_pc = 0x1200 (same index, different tag) -> 0x1204.
REQ-033 Branch pc = 0x40, target = 0x10, taken once with GHR = 0 -> counter 2'b10, GHR = 1; lookup of 0x40 uses index 16 XOR 1 = 17 (counter 01) -> predicted_pc = 0x44.
REQ-034 Five consecutive not-taken updates of one branch -> counter pinned at 2'b00 (no wrap), GHR = 0; four taken updates with GHR held -> counter pinned at 2'b11.
REQ-035 Update and lookup of pc 0x300 in the same cycle -> old prediction that cycle, new prediction the next cycle.
REQ-036 Reset asserted with update_valid = 1 after training -> all lookups return pc + 4 next cycle.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with a gshare-style 2-bit pattern table.
// Lookup is combinational from current_pc; resolved branches and jumps train the tables on the clock edge.
module branch_target_predictor #(
  parameter int ENTRIES = 32,
  parameter int HIST    = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  output logic [31:0] predicted_pc,
  output logic        predict_taken,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic        update_is_jump,
  input  logic        update_is_branch
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [TW-1:0]      tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         pht_q    [ENTRIES];
  logic [HIST-1:0]    ghr_q;
  logic [HIST-1:0]    ghr_d;

  logic [IW-1:0] ghr_ext;
  logic [IW-1:0] lk_idx;
  logic [IW-1:0] lk_pht_idx;
  logic [TW-1:0] lk_tag;
  logic          lk_hit;
  logic [1:0]    lk_cnt;

  logic [IW-1:0] upd_idx;
  logic [IW-1:0] upd_pht_idx;
  logic [TW-1:0] upd_tag;
  logic          upd_en;
  logic          btb_we;
  logic          btb_jump_d;
  logic          pht_we;
  logic [1:0]    pht_cur;
  logic [1:0]    pht_cnt_d;
  logic [HIST:0] ghr_shift;

  logic unused_bits;
  assign unused_bits = ^{current_pc[1:0], update_pc[1:0]};

  assign ghr_ext     = IW'(ghr_q);
  assign lk_idx      = current_pc[IW+1:2];
  assign lk_tag      = current_pc[31:IW+2];
  assign lk_pht_idx  = lk_idx ^ ghr_ext;
  assign upd_idx     = update_pc[IW+1:2];
  assign upd_tag     = update_pc[31:IW+2];
  assign upd_pht_idx = upd_idx ^ ghr_ext;
  assign upd_en      = update_valid && !reset;
  assign ghr_shift   = {ghr_q, update_taken};

  // Reset forces the not-taken path so stale or uninitialised entries never leak out.
  always_comb begin
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_cnt        = pht_q[lk_pht_idx];
    predict_taken = !reset && lk_hit && (jump_q[lk_idx] || lk_cnt[1]);
    predicted_pc  = predict_taken ? target_q[lk_idx] : current_pc + 32'd4;
  end

  // Jump wins over branch when both flags are set; PHT/GHR then stay put.
  always_comb begin
    btb_we     = 1'b0;
    btb_jump_d = 1'b0;
    pht_we     = 1'b0;
    pht_cur    = pht_q[upd_pht_idx];
    pht_cnt_d  = pht_cur;
    ghr_d      = ghr_q;
    if (upd_en) begin
      if (update_is_jump) begin
        btb_we     = 1'b1;
        btb_jump_d = 1'b1;
      end else if (update_is_branch) begin
        pht_we = 1'b1;
        ghr_d  = ghr_shift[HIST-1:0];
        if (update_taken) begin
          btb_we    = 1'b1;
          pht_cnt_d = (pht_cur == 2'b11) ? 2'b11 : pht_cur + 2'd1;
        end else begin
          pht_cnt_d = (pht_cur == 2'b00) ? 2'b00 : pht_cur - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      ghr_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= 2'b01;
      end
    end else begin
      if (btb_we) begin
        valid_q[upd_idx] <= 1'b1;
      end
      if (pht_we) begin
        pht_q[upd_pht_idx] <= pht_cnt_d;
      end
      ghr_q <= ghr_d;
    end
  end

  // Payload fields are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (btb_we) begin
      jump_q[upd_idx]   <= btb_jump_d;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= update_target;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed vector table followed by random traffic
// compared against an array-based reference model of the predictor rules.
module tb_branch_target_predictor;

  localparam int ENTRIES = 32;
  localparam int IW      = 5;
  localparam int HIST    = 5;

  logic        clk;
  logic        reset;
  logic [31:0] current_pc;
  logic [31:0] predicted_pc;
  logic        predict_taken;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        update_is_jump;
  logic        update_is_branch;

  int checks = 0;
  int errors = 0;

  branch_target_predictor #(.ENTRIES(ENTRIES), .HIST(HIST)) dut (
    .clk              (clk),
    .reset            (reset),
    .current_pc       (current_pc),
    .predicted_pc     (predicted_pc),
    .predict_taken    (predict_taken),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_target    (update_target),
    .update_taken     (update_taken),
    .update_is_jump   (update_is_jump),
    .update_is_branch (update_is_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        ut;
    logic        uj;
    logic        ub;
    logic [31:0] exp_pc;
    logic        exp_tk;
  } vec_t;

  // Reference model state
  bit          m_valid [ENTRIES];
  bit          m_jump  [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_target[ENTRIES];
  int          m_pht   [ENTRIES];
  int unsigned m_ghr;

  function automatic vec_t mk(input logic rst, input logic [31:0] pc, input logic uv,
                              input logic [31:0] upc, input logic [31:0] utgt,
                              input logic ut, input logic uj, input logic ub,
                              input logic [31:0] exp_pc, input logic exp_tk);
    vec_t v;
    v.rst = rst; v.pc = pc; v.uv = uv; v.upc = upc; v.utgt = utgt;
    v.ut = ut; v.uj = uj; v.ub = ub; v.exp_pc = exp_pc; v.exp_tk = exp_tk;
    return v;
  endfunction

  task automatic model_apply(input vec_t v);
    int unsigned i;
    int unsigned p;
    if (v.rst) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 0;
        m_pht[k]   = 1;
      end
      m_ghr = 0;
    end else if (v.uv) begin
      i = (v.upc >> 2) % ENTRIES;
      if (v.uj) begin
        m_valid[i] = 1; m_jump[i] = 1; m_tag[i] = v.upc >> (IW + 2); m_target[i] = v.utgt;
      end else if (v.ub) begin
        p = i ^ m_ghr;
        if (v.ut) begin
          m_valid[i] = 1; m_jump[i] = 0; m_tag[i] = v.upc >> (IW + 2); m_target[i] = v.utgt;
          if (m_pht[p] < 3) m_pht[p]++;
        end else if (m_pht[p] > 0) begin
          m_pht[p]--;
        end
        m_ghr = ((m_ghr << 1) | int'(v.ut)) % (1 << HIST);
      end
    end
  endtask

  task automatic model_predict(input logic rst, input logic [31:0] pc,
                               output logic [31:0] epc, output logic etk);
    int unsigned i;
    bit hit;
    i   = (pc >> 2) % ENTRIES;
    hit = m_valid[i] && (m_tag[i] == (pc >> (IW + 2)));
    etk = !rst && hit && (m_jump[i] || m_pht[i ^ m_ghr] >= 2);
    epc = etk ? m_target[i] : pc + 32'd4;
  endtask

  task automatic drive(input vec_t v);
    reset            = v.rst;
    current_pc       = v.pc;
    update_valid     = v.uv;
    update_pc        = v.upc;
    update_target    = v.utgt;
    update_taken     = v.ut;
    update_is_jump   = v.uj;
    update_is_branch = v.ub;
  endtask

  task automatic compare(input string name, input logic [31:0] epc, input logic etk);
    checks++;
    if (predicted_pc !== epc || predict_taken !== etk) begin
      errors++;
      $display("FAIL %s pc=%08h got predicted_pc=%08h predict_taken=%0b want predicted_pc=%08h predict_taken=%0b",
               name, current_pc, predicted_pc, predict_taken, epc, etk);
    end
  endtask

  vec_t tbl[$];

  initial begin
    vec_t        v;
    logic [31:0] epc;
    logic        etk;

    tbl.push_back(mk(1, 32'h100, 1, 32'h100, 32'h500, 0, 1, 0, 32'h104, 0));
    tbl.push_back(mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 32'h104, 0));
    tbl.push_back(mk(0, 32'h200, 1, 32'h200, 32'h800, 0, 1, 0, 32'h204, 0));
    tbl.push_back(mk(0, 32'h200, 0, 0, 0, 0, 0, 0, 32'h800, 1));
    tbl.push_back(mk(0, 32'h1200, 0, 0, 0, 0, 0, 0, 32'h1204, 0));
    tbl.push_back(mk(0, 32'h40, 1, 32'h40, 32'h10, 1, 0, 1, 32'h44, 0));
    tbl.push_back(mk(0, 32'h40, 0, 0, 0, 0, 0, 0, 32'h44, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 32'h40, 1, 32'h40, 32'h10, 0, 0, 1, 32'h44, 0));
    tbl.push_back(mk(0, 32'h40, 0, 0, 0, 0, 0, 0, 32'h10, 1));
    tbl.push_back(mk(0, 32'h40, 1, 32'h40, 32'h10, 0, 0, 1, 32'h10, 1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 32'h40, 1, 32'h40, 32'h10, 0, 0, 1, 32'h44, 0));
    tbl.push_back(mk(0, 32'h40, 0, 0, 0, 0, 0, 0, 32'h44, 0));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(0, 32'h40, 1, 32'h40, 32'h10, 1, 0, 1, 32'h44, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 32'h40, 1, 32'h40, 32'h10, 1, 0, 1, 32'h10, 1));
    tbl.push_back(mk(0, 32'h300, 1, 32'h300, 32'h900, 0, 1, 0, 32'h304, 0));
    tbl.push_back(mk(0, 32'h300, 0, 0, 0, 0, 0, 0, 32'h900, 1));
    tbl.push_back(mk(0, 32'h200, 0, 0, 0, 0, 0, 0, 32'h204, 0));
    tbl.push_back(mk(0, 32'h100, 1, 32'h100, 32'h700, 0, 0, 0, 32'h104, 0));
    tbl.push_back(mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 32'h104, 0));
    tbl.push_back(mk(0, 32'h40, 0, 0, 0, 0, 0, 0, 32'h10, 1));
    tbl.push_back(mk(0, 32'h40, 1, 32'h40, 32'h20, 0, 1, 1, 32'h10, 1));
    tbl.push_back(mk(0, 32'h40, 0, 0, 0, 0, 0, 0, 32'h20, 1));
    tbl.push_back(mk(1, 32'h300, 1, 32'h500, 32'hA00, 0, 1, 0, 32'h304, 0));
    tbl.push_back(mk(0, 32'h300, 0, 0, 0, 0, 0, 0, 32'h304, 0));
    tbl.push_back(mk(0, 32'h40, 0, 0, 0, 0, 0, 0, 32'h44, 0));
    tbl.push_back(mk(0, 32'h500, 0, 0, 0, 0, 0, 0, 32'h504, 0));
    tbl.push_back(mk(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k]);
      #3;
      compare($sformatf("vec%0d", k), tbl[k].exp_pc, tbl[k].exp_tk);
      @(posedge clk);
      model_apply(tbl[k]);
      #1;
    end

    // Random traffic over a few tags per index so hits and aliasing both occur.
    for (int n = 0; n < 3000; n++) begin
      v.rst  = ($urandom_range(0, 299) == 0);
      v.pc   = ($urandom_range(0, 15) == 0) ? $urandom() & 32'hFFFF_FFFC
                                            : (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
      v.uv   = ($urandom_range(0, 3) != 0);
      v.upc  = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
      v.utgt = $urandom() & 32'hFFFF_FFFC;
      v.ut   = 1'($urandom_range(0, 1));
      v.uj   = ($urandom_range(0, 4) == 0);
      v.ub   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) v.pc = v.upc;
      drive(v);
      #3;
      model_predict(v.rst, v.pc, epc, etk);
      compare($sformatf("rand%0d", n), epc, etk);
      @(posedge clk);
      model_apply(v);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
